// File: rtl/nios_ii_led_seq_if.sv
// Avalon-MM slave bus bundle for the LED pattern sequencer.
// Zero-wait-state: readdata is a combinational function of address.
interface nios_ii_led_seq_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_ii_led_seq.sv
// LED pattern sequencer behind the Nios II: plays up to 8 stored patterns at a
// programmable step period (one-shot or loop), otherwise drives the MANUAL value.
//
// state | meaning
// IDLE  | out_port follows MANUAL; sequencer stopped
// RUN   | stepping through PATTERN[0..LAST], counter times each step
module nios_ii_led_seq #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  nios_ii_led_seq_if.slave bus,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pattern [8];
  logic [WIDTH-1:0] manual, manual_nx, out_nx;
  logic [CNT_W-1:0] period, cnt, cnt_nx, reload;
  logic [2:0]       last, idx, idx_nx;
  logic             loop, done, done_nx;
  logic             wr, wr_ctrl, start, stop, clr_done;
  logic             unused_bits;

  assign wr       = bus.chipselect && !bus.write_n;
  assign wr_ctrl  = wr && (bus.address == 4'd0);
  assign stop     = wr_ctrl && bus.writedata[1];
  assign start    = wr_ctrl && bus.writedata[0] && !bus.writedata[1];
  assign clr_done = wr && (bus.address == 4'd3) && bus.writedata[1];
  assign reload   = (period == '0) ? '0 : period - CNT_W'(1);
  assign busy     = (state == RUN);
  assign unused_bits = ^bus.writedata;

  // Bypass so a MANUAL write reaches the pins one cycle after the write cycle
  assign manual_nx = (wr && bus.address == 4'd4) ? bus.writedata[WIDTH-1:0] : manual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loop   <= 1'b0;
      period <= '0;
      last   <= '0;
      manual <= '0;
      for (int i = 0; i < 8; i++) pattern[i] <= '0;
    end else if (wr) begin
      if (bus.address[3]) begin
        pattern[bus.address[2:0]] <= bus.writedata[WIDTH-1:0];
      end else begin
        case (bus.address)
          4'd0:    loop   <= bus.writedata[2];
          4'd1:    period <= bus.writedata[CNT_W-1:0];
          4'd2:    last   <= bus.writedata[2:0];
          4'd4:    manual <= bus.writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      out_port <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      out_port <= out_nx;
      done     <= done_nx;
    end
  end

  // idx >= last (not ==) so lowering LAST mid-run ends/wraps at the next boundary
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    out_nx   = out_port;
    done_nx  = done && !clr_done;
    if (stop) begin
      state_nx = IDLE;
      out_nx   = manual_nx;
    end else if (start) begin
      state_nx = RUN;
      idx_nx   = '0;
      cnt_nx   = reload;
      out_nx   = pattern[0];
      done_nx  = 1'b0;
    end else if (state == IDLE) begin
      out_nx = manual_nx;
    end else if (cnt != '0) begin
      cnt_nx = cnt - CNT_W'(1);
    end else if (idx < last) begin
      idx_nx = idx + 3'd1;
      cnt_nx = reload;
      out_nx = pattern[idx + 3'd1];
    end else if (loop) begin
      idx_nx = '0;
      cnt_nx = reload;
      out_nx = pattern[0];
    end else begin
      state_nx = IDLE;
      done_nx  = 1'b1;
      out_nx   = manual_nx;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.address[3]) begin
      bus.readdata[WIDTH-1:0] = pattern[bus.address[2:0]];
    end else begin
      case (bus.address)
        4'd0:    bus.readdata[2]         = loop;
        4'd1:    bus.readdata[CNT_W-1:0] = period;
        4'd2:    bus.readdata[2:0]       = last;
        4'd3:    bus.readdata[6:0]       = {idx, 2'b00, done, busy};
        4'd4:    bus.readdata[WIDTH-1:0] = manual;
        default: ;
      endcase
    end
  end

endmodule
